bubble_alu: RTL and testbench
=============================

Name: bubble_alu

Overview:
- Unified execute-stage ALU for the CSE BUBBLE processor, sitting between decode and writeback/PC-update.
- Merges three datapaths into one registered block:
  - R-type register ALU (selected by funct).
  - I-type immediate ALU (selected by alu_op).
  - J-type next-PC unit.
- Outputs are captured on the rising clock edge, so results appear one cycle after issue.

Parameters:
- XLEN, 32, datapath width of rs/rt/imm/pc/rd/new_pc.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  issue strobe; operands are sampled when high
- op_class  input  2  instruction class: 00=R, 01=I, 10=J, 11=reserved
- rs  input  32  source operand A for R/I classes
- rt  input  32  source operand B for R class
- imm  input  32  immediate, already extended by decode
- funct  input  6  R-type function code
- alu_op  input  6  I-type opcode
- pc  input  32  current PC
- target  input  26  J-type jump index
- jump_en  input  1  J-type jump taken
- rd  output  32  registered result
- new_pc  output  32  registered next PC
- zero  output  1  registered zero flag
- carry_out  output  1  registered carry flag
- out_valid  output  1  high one cycle after an accepted in_valid

Behaviour:
- Reset:
  - Sampled on the rising edge while rst_n=0; it dominates in_valid.
  - rd, new_pc, zero, carry_out and out_valid all clear to 0.
- Latency and issue:
  - Latency is exactly 1 cycle.
  - On an edge with in_valid=1, the result of the current inputs is registered and out_valid=1.
  - With in_valid=0, out_valid=0 and the data outputs hold their previous values.
  - Back-to-back issue every cycle is supported.
- Add/sub arithmetic (33-bit, unsigned carry):
  - add: {c,r} = A + B.
  - sub: {c,r} = A + ~B + 1, so carry=1 means no borrow (A >= B unsigned).
  - Overflow is not trapped.
- R class (A=rs, B=rt), by funct:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu: carry as defined above.
  - 100100 and, 100101 or, 100110 xor, 100111 nor.
  - 101010 slt (signed), 101011 sltu: result 0/1.
  - 000000 sll, 000010 srl, 000011 sra: shift amount rs[4:0], value rt.
- I class (A=rs, B=imm), by alu_op:
  - 001000 addi, 001001 addiu, 011010 subi.
  - 001100 andi, 001101 ori, 001110 xori.
  - 001010 slti, 001011 sltiu.
  - 001111 lui: result imm[15:0]<<16.
- Flags for R/I classes:
  - carry_out is 0 for every non-add/sub operation.
  - zero = (rd==0).
  - new_pc = pc+4 (wraps mod 2^32).
- J class:
  - pc4 = pc + 4.
  - new_pc = jump_en ? {pc4[31:28], target, 2'b00} : pc4.
  - rd = pc4 (link value).
  - zero=1, carry_out=0.
- Undefined funct/alu_op, or op_class=11:
  - rd=0, zero=1, carry_out=0, new_pc=pc+4.
  - out_valid still asserts.
- Wrap-around:
  - 0xFFFFFFFF+1 gives rd=0, zero=1, carry=1.
  - pc=0xFFFFFFFC gives pc4=0.
- Mid-operation reset: an issue on the same edge as reset is discarded.

Test Plan:
1. R add: rs=10, rt=20, funct=100000, in_valid pulse -> next cycle rd=30, zero=0, carry_out=0, out_valid=1.
2. R sub: rs=20, rt=10, funct=100010 -> rd=10, zero=0, carry_out=1. Then rs=10, rt=20 -> rd=0xFFFFFFF6, carry_out=0.
3. I ops:
   - addi rs=10, imm=5, alu_op=001000 -> rd=15, carry_out=0.
   - subi rs=20, imm=10, alu_op=011010 -> rd=10, carry_out=1.
   - subi rs=7, imm=7 -> rd=0, zero=1.
4. J: pc=100, target=10, op_class=10, jump_en=0 -> new_pc=104, rd=104, zero=1, carry_out=0. With jump_en=1 -> new_pc=40.
5. Boundaries:
   - add 0xFFFFFFFF+1 -> rd=0, zero=1, carry_out=1.
   - sra rt=0x80000000, rs=4 -> rd=0xF8000000.
   - slt rs=-1, rt=1 -> rd=1; sltu on the same operands -> rd=0.
6. Reset/hold:
   - Assert rst_n=0 during an issue -> all outputs 0 next edge.
   - in_valid=0 for 3 cycles -> outputs held, out_valid=0.
   - Undefined funct 111111 -> rd=0, zero=1.

Source files
------------

// File: rtl/bubble_alu.sv
// rtl/bubble_alu.sv - execute-stage ALU merging R-type, I-type and J-type datapaths
// All results are registered: issue on one edge, results visible after that edge.
module bubble_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [1:0]      op_class,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic [XLEN-1:0] imm,
  input  logic [5:0]      funct,
  input  logic [5:0]      alu_op,
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     target,
  input  logic            jump_en,
  output logic [XLEN-1:0] rd,
  output logic [XLEN-1:0] new_pc,
  output logic            zero,
  output logic            carry_out,
  output logic            out_valid
);

  localparam logic [1:0] CLS_R = 2'b00;
  localparam logic [1:0] CLS_I = 2'b01;
  localparam logic [1:0] CLS_J = 2'b10;

  logic [XLEN-1:0] rd_q, rd_d, new_pc_q, new_pc_d;
  logic            zero_q, zero_d, carry_q, carry_d, out_valid_q, out_valid_d;

  logic [XLEN-1:0] opb, res, pc4;
  logic [XLEN:0]   sum;
  logic            arith, use_sub;

  always_comb begin
    res     = '0;
    arith   = 1'b0;
    use_sub = 1'b0;
    opb     = rt;
    pc4     = pc + XLEN'(4);
    case (op_class)
      CLS_R: begin
        case (funct)
          6'b100000, 6'b100001: arith = 1'b1;
          6'b100010, 6'b100011: begin arith = 1'b1; use_sub = 1'b1; end
          6'b100100: res = rs & rt;
          6'b100101: res = rs | rt;
          6'b100110: res = rs ^ rt;
          6'b100111: res = ~(rs | rt);
          6'b101010: res = XLEN'($signed(rs) < $signed(rt));
          6'b101011: res = XLEN'(rs < rt);
          6'b000000: res = rt << rs[4:0];
          6'b000010: res = rt >> rs[4:0];
          6'b000011: res = $signed(rt) >>> rs[4:0];
          default:   res = '0;
        endcase
      end
      CLS_I: begin
        opb = imm;
        case (alu_op)
          6'b001000, 6'b001001: arith = 1'b1;
          6'b011010: begin arith = 1'b1; use_sub = 1'b1; end
          6'b001100: res = rs & imm;
          6'b001101: res = rs | imm;
          6'b001110: res = rs ^ imm;
          6'b001010: res = XLEN'($signed(rs) < $signed(imm));
          6'b001011: res = XLEN'(rs < imm);
          6'b001111: res = XLEN'({imm[15:0], 16'h0000});
          default:   res = '0;
        endcase
      end
      CLS_J:   res = pc4;
      default: res = '0;
    endcase
    // Subtraction as A + ~B + 1 so the carry bit reads as "no borrow".
    sum = {1'b0, rs} + {1'b0, (use_sub ? ~opb : opb)} + (XLEN+1)'(use_sub);
    if (arith) res = sum[XLEN-1:0];
  end

  always_comb begin
    rd_d        = rd_q;
    new_pc_d    = new_pc_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      rd_d        = res;
      new_pc_d    = (op_class == CLS_J && jump_en) ? {pc4[XLEN-1:28], target, 2'b00} : pc4;
      zero_d      = (op_class == CLS_J) ? 1'b1 : (res == '0);
      carry_d     = arith & sum[XLEN];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q        <= '0;
      new_pc_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      new_pc_q    <= new_pc_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd        = rd_q;
  assign new_pc    = new_pc_q;
  assign zero      = zero_q;
  assign carry_out = carry_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bubble_alu.sv
// tb/tb_bubble_alu.sv - directed self-checking bench for bubble_alu
module tb_bubble_alu;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, jump_en;
  logic [1:0]  op_class;
  logic [31:0] rs, rt, imm, pc;
  logic [5:0]  funct, alu_op;
  logic [25:0] target;
  logic [31:0] rd, new_pc;
  logic        zero, carry_out, out_valid;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
  } vec_t;

  bubble_alu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op_class(op_class),
    .rs(rs), .rt(rt), .imm(imm), .funct(funct), .alu_op(alu_op), .pc(pc),
    .target(target), .jump_en(jump_en), .rd(rd), .new_pc(new_pc),
    .zero(zero), .carry_out(carry_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] cls, input logic [5:0] code, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] p, input logic [25:0] tg,
                       input logic je);
    @(negedge clk);
    in_valid = 1'b1; op_class = cls; rs = a; rt = b; imm = b;
    funct = code; alu_op = code; pc = p; target = tg; jump_en = je;
    @(posedge clk); #1;
  endtask

  task automatic check_vecs(input string tag, input logic [1:0] cls, input vec_t v[$]);
    for (int i = 0; i < v.size(); i++) begin
      issue(cls, v[i].op, v[i].a, v[i].b, 32'd100, 26'd0, 1'b0);
      checks++;
      if (rd !== v[i].r) begin
        failures++; $display("FAIL %s_rd[%0d] got=%h exp=%h", tag, i, rd, v[i].r);
      end
      checks++;
      if (carry_out !== v[i].c) begin
        failures++; $display("FAIL %s_carry[%0d] got=%b exp=%b", tag, i, carry_out, v[i].c);
      end
      checks++;
      if (zero !== (v[i].r == 32'd0)) begin
        failures++; $display("FAIL %s_zero[%0d] got=%b exp=%b", tag, i, zero, (v[i].r == 32'd0));
      end
      checks++;
      if (new_pc !== 32'd104 || out_valid !== 1'b1) begin
        failures++; $display("FAIL %s_pc_valid[%0d] got=%h/%b exp=%h/1", tag, i, new_pc, out_valid, 32'd104);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; op_class = 2'b00; rs = '0; rt = '0; imm = '0;
    funct = '0; alu_op = '0; pc = '0; target = '0; jump_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rd, new_pc, zero, carry_out, out_valid} !== 67'd0) begin
      failures++; $display("FAIL reset_state got rd=%h pc=%h z=%b c=%b v=%b exp all 0", rd, new_pc, zero, carry_out, out_valid);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_r_ops;
    vec_t v[$];
    v.push_back({6'b100000, 32'd10, 32'd20, 32'd30, 1'b0});
    v.push_back({6'b100010, 32'd20, 32'd10, 32'd10, 1'b1});
    v.push_back({6'b100011, 32'd10, 32'd20, 32'hFFFFFFF6, 1'b0});
    v.push_back({6'b100001, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1});
    v.push_back({6'b100100, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0});
    v.push_back({6'b100101, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0});
    v.push_back({6'b100110, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0});
    v.push_back({6'b100111, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0});
    v.push_back({6'b101010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0});
    v.push_back({6'b101011, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0});
    v.push_back({6'b000000, 32'd4, 32'd1, 32'd16, 1'b0});
    v.push_back({6'b000010, 32'd4, 32'h80000000, 32'h08000000, 1'b0});
    v.push_back({6'b000011, 32'd4, 32'h80000000, 32'hF8000000, 1'b0});
    v.push_back({6'b111111, 32'd5, 32'd6, 32'd0, 1'b0});
    check_vecs("r", 2'b00, v);
  endtask

  task automatic test_i_ops;
    vec_t v[$];
    v.push_back({6'b001000, 32'd10, 32'd5, 32'd15, 1'b0});
    v.push_back({6'b011010, 32'd20, 32'd10, 32'd10, 1'b1});
    v.push_back({6'b011010, 32'd7, 32'd7, 32'd0, 1'b1});
    v.push_back({6'b001001, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1});
    v.push_back({6'b001100, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0});
    v.push_back({6'b001101, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0});
    v.push_back({6'b001110, 32'h0000F0F0, 32'h00000FF0, 32'h0000FF00, 1'b0});
    v.push_back({6'b001010, 32'hFFFFFFFE, 32'd1, 32'd1, 1'b0});
    v.push_back({6'b001011, 32'hFFFFFFFE, 32'd1, 32'd0, 1'b0});
    v.push_back({6'b001111, 32'd0, 32'hABCD1234, 32'h12340000, 1'b0});
    v.push_back({6'b000000, 32'd9, 32'd9, 32'd0, 1'b0});
    check_vecs("i", 2'b01, v);
  endtask

  task automatic test_jump;
    logic [31:0] exp_pc [4] = '{32'd104, 32'd40, 32'd0, 32'h0FFFFFFC};
    logic [31:0] exp_rd [4] = '{32'd104, 32'd104, 32'd0, 32'd0};
    logic [31:0] pcs    [4] = '{32'd100, 32'd100, 32'hFFFFFFFC, 32'hFFFFFFFC};
    logic [25:0] tgs    [4] = '{26'd10, 26'd10, 26'd5, 26'h3FFFFFF};
    logic        jes    [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(2'b10, 6'd0, 32'h12345678, 32'h9, pcs[i], tgs[i], jes[i]);
      checks++;
      if (new_pc !== exp_pc[i] || rd !== exp_rd[i]) begin
        failures++; $display("FAIL j_pc_rd[%0d] got=%h/%h exp=%h/%h", i, new_pc, rd, exp_pc[i], exp_rd[i]);
      end
      checks++;
      if (zero !== 1'b1 || carry_out !== 1'b0 || out_valid !== 1'b1) begin
        failures++; $display("FAIL j_flags[%0d] got z=%b c=%b v=%b exp 1/0/1", i, zero, carry_out, out_valid);
      end
    end
    issue(2'b11, 6'b100000, 32'd3, 32'd4, 32'd200, 26'd0, 1'b1);
    checks++;
    if (rd !== 32'd0 || zero !== 1'b1 || carry_out !== 1'b0 || new_pc !== 32'd204 || out_valid !== 1'b1) begin
      failures++; $display("FAIL reserved_class got rd=%h z=%b c=%b pc=%h v=%b exp 0/1/0/000000cc/1", rd, zero, carry_out, new_pc, out_valid);
    end
  endtask

  task automatic test_back_to_back;
    issue(2'b00, 6'b100000, 32'd1, 32'd2, 32'd0, 26'd0, 1'b0);
    checks++;
    if (rd !== 32'd3 || out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_0 got=%h/%b exp=3/1", rd, out_valid);
    end
    issue(2'b01, 6'b001000, 32'd100, 32'd23, 32'd8, 26'd0, 1'b0);
    checks++;
    if (rd !== 32'd123 || new_pc !== 32'd12 || out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_1 got=%h/%h/%b exp=7b/c/1", rd, new_pc, out_valid);
    end
    issue(2'b10, 6'd0, 32'd0, 32'd0, 32'd16, 26'd1, 1'b1);
    checks++;
    if (rd !== 32'd20 || new_pc !== 32'd4 || out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_2 got=%h/%h/%b exp=14/4/1", rd, new_pc, out_valid);
    end
  endtask

  task automatic test_hold;
    issue(2'b00, 6'b100010, 32'd50, 32'd8, 32'd64, 26'd0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rs = 32'hDEADBEEF; rt = 32'h1; pc = 32'h400;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rd !== 32'd42 || new_pc !== 32'd68 || zero !== 1'b0 || carry_out !== 1'b1 || out_valid !== 1'b0) begin
        failures++; $display("FAIL hold[%0d] got rd=%h pc=%h z=%b c=%b v=%b exp 2a/44/0/1/0", i, rd, new_pc, zero, carry_out, out_valid);
      end
    end
  endtask

  task automatic test_mid_reset;
    issue(2'b00, 6'b100001, 32'hFFFFFFFF, 32'd1, 32'd0, 26'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; op_class = 2'b00; funct = 6'b100000; rs = 32'd5; rt = 32'd6;
    @(posedge clk); #1;
    checks++;
    if ({rd, new_pc, zero, carry_out, out_valid} !== 67'd0) begin
      failures++; $display("FAIL mid_reset got rd=%h pc=%h z=%b c=%b v=%b exp all 0", rd, new_pc, zero, carry_out, out_valid);
    end
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || rd !== 32'd0) begin
      failures++; $display("FAIL post_reset got rd=%h v=%b exp 0/0", rd, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_r_ops();
    test_i_ops();
    test_jump();
    test_back_to_back();
    test_hold();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
